// File: rtl/bp_be_pkg.sv
// Shared types for the long-latency integer divide pipe.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_idiv_div  = 2'd0,
    e_idiv_divu = 2'd1,
    e_idiv_rem  = 2'd2,
    e_idiv_remu = 2'd3
  } bp_be_idiv_op_e;

  typedef enum logic [1:0] {
    e_idiv_idle = 2'd0,
    e_idiv_calc = 2'd1,
    e_idiv_fix  = 2'd2
  } bp_be_idiv_state_e;

  localparam int unsigned dword_width_gp    = 64;
  localparam int unsigned reg_addr_width_gp = 5;

  // One result-queue entry at the default machine widths.
  typedef struct packed {
    logic [dword_width_gp-1:0]    data;
    logic [reg_addr_width_gp-1:0] rd_addr;
  } bp_be_idiv_entry_s;

endpackage

// File: rtl/bp_be_idiv_iter_core.sv
// Restoring radix-2 shift/subtract divider on unsigned magnitudes.
module bp_be_idiv_iter_core #(
  parameter int unsigned width_p  = 64,
  parameter int unsigned n_width_p = $clog2(width_p + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 start_i,
  input  logic                 kill_i,
  input  logic [width_p-1:0]   dividend_i,
  input  logic [width_p-1:0]   divisor_i,
  input  logic [n_width_p-1:0] n_i,
  output logic [width_p-1:0]   quotient_o,
  output logic [width_p-1:0]   remainder_o,
  output logic                 done_o
);

  localparam logic [n_width_p-1:0] width_lp = n_width_p'(width_p);

  logic [width_p-1:0]   quo_q, quo_d, rem_q, rem_d, div_q, div_d;
  logic [n_width_p-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic [width_p:0]     rem_sh, diff;

  // One iteration per cycle; a short op is pre-shifted so its MSB starts at the top.
  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    rem_sh = {rem_q, quo_q[width_p-1]};
    diff   = rem_sh - {1'b0, div_q};
    if (kill_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      quo_d  = dividend_i << (width_lp - n_i);
      rem_d  = '0;
      div_d  = divisor_i;
      cnt_d  = n_i - n_width_p'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      quo_d = {quo_q[width_p-2:0], ~diff[width_p]};
      rem_d = diff[width_p] ? rem_sh[width_p-1:0] : diff[width_p-1:0];
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - n_width_p'(1);
      end
    end
  end

  // Datapath and iteration counter state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      quo_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign done_o      = busy_q && (cnt_q == '0);

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small in-order FIFO with show-ahead head and synchronous clear.
module bsg_fifo_1r1w_small #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 2,
  parameter int unsigned cnt_width_p = $clog2(els_p + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   clear_i,
  input  logic                   v_i,
  input  logic [width_p-1:0]     data_i,
  output logic                   v_o,
  output logic [width_p-1:0]     data_o,
  input  logic                   yumi_i,
  output logic [cnt_width_p-1:0] count_o
);

  localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(els_p - 1);

  logic [width_p-1:0]     mem [els_p];
  logic [ptr_w_lp-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_width_p-1:0] count_q, count_d;
  logic                   push, pop;

  // Pointer and occupancy update; clear wins over push and pop.
  always_comb begin
    push     = v_i && !clear_i;
    pop      = yumi_i && !clear_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == last_lp) ? '0 : wr_ptr_q + ptr_w_lp'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == last_lp) ? '0 : rd_ptr_q + ptr_w_lp'(1);
      if (push && !pop)      count_d = count_q + cnt_width_p'(1);
      else if (pop && !push) count_d = count_q - cnt_width_p'(1);
    end
  end

  // Pointer/count state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem[rd_ptr_q];
  assign v_o     = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/bp_be_pipe_long_idiv_mc.sv
// Multi-cycle divide/remainder pipe: FSM, sign/special handling, result queue.
module bp_be_pipe_long_idiv_mc
  import bp_be_pkg::*;
#(
  parameter int unsigned width_p         = 64,
  parameter int unsigned word_width_p    = 32,
  parameter int unsigned els_p           = 2,
  parameter int unsigned rd_addr_width_p = 5
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  output logic                       ready_and_o,
  input  logic [1:0]                 op_i,
  input  logic                       opw_i,
  input  logic [rd_addr_width_p-1:0] rd_addr_i,
  input  logic [width_p-1:0]         a_i,
  input  logic [width_p-1:0]         b_i,
  input  logic                       flush_i,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  output logic [rd_addr_width_p-1:0] rd_addr_o,
  input  logic                       yumi_i
);

  localparam int unsigned n_w_lp   = $clog2(width_p + 1);
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);
  localparam int unsigned ext_lp   = width_p - word_width_p;
  localparam logic [width_p-1:0] dmin_lp = {1'b1, {(width_p-1){1'b0}}};
  localparam logic [width_p-1:0] wmin_lp = {{(ext_lp+1){1'b1}}, {(word_width_p-1){1'b0}}};

  bp_be_idiv_state_e state_q, state_d;
  bp_be_idiv_op_e    op_e;
  logic accept, push, start, core_done, is_signed, is_rem, a_neg, b_neg, div_zero, ovf, fast;
  logic [width_p-1:0] a_eff, b_eff, a_mag, b_mag, spec_res, quo, rem, res_raw, res;
  logic [width_p-1:0] spec_res_q, spec_res_d;
  logic [rd_addr_width_p-1:0] rd_q, rd_d;
  logic special_q, special_d, is_rem_q, is_rem_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d, opw_q, opw_d;
  logic [cnt_w_lp-1:0] q_count;

  // Operand preparation straight from the issue ports.
  always_comb begin
    op_e      = bp_be_idiv_op_e'(op_i);
    is_signed = (op_e == e_idiv_div) || (op_e == e_idiv_rem);
    is_rem    = (op_e == e_idiv_rem) || (op_e == e_idiv_remu);
    a_eff     = a_i;
    b_eff     = b_i;
    if (opw_i) begin
      a_eff = {{ext_lp{is_signed & a_i[word_width_p-1]}}, a_i[word_width_p-1:0]};
      b_eff = {{ext_lp{is_signed & b_i[word_width_p-1]}}, b_i[word_width_p-1:0]};
    end
    a_neg    = is_signed && a_eff[width_p-1];
    b_neg    = is_signed && b_eff[width_p-1];
    a_mag    = a_neg ? -a_eff : a_eff;
    b_mag    = b_neg ? -b_eff : b_eff;
    div_zero = (b_eff == '0);
    ovf      = is_signed && (b_eff == '1) && (a_eff == (opw_i ? wmin_lp : dmin_lp));
    fast     = div_zero || ovf;
    if (div_zero) spec_res = is_rem ? a_eff : '1;
    else          spec_res = is_rem ? '0 : a_eff;
  end

  // Per-op context captured on accept for the fix-up cycle.
  always_comb begin
    spec_res_d = spec_res_q;
    rd_d       = rd_q;
    special_d  = special_q;
    is_rem_d   = is_rem_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    opw_d      = opw_q;
    if (accept) begin
      spec_res_d = spec_res;
      rd_d       = rd_addr_i;
      special_d  = fast;
      is_rem_d   = is_rem;
      q_neg_d    = a_neg ^ b_neg;
      r_neg_d    = a_neg;
      opw_d      = opw_i;
    end
  end

  // FSM state register and captured context.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= e_idiv_idle;
      spec_res_q <= '0;
      rd_q       <= '0;
      special_q  <= 1'b0;
      is_rem_q   <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      opw_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      spec_res_q <= spec_res_d;
      rd_q       <= rd_d;
      special_q  <= special_d;
      is_rem_q   <= is_rem_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      opw_q      <= opw_d;
    end
  end

  // Next-state logic; flush forces IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      e_idiv_idle: if (accept) state_d = fast ? e_idiv_fix : e_idiv_calc;
      e_idiv_calc: if (core_done) state_d = e_idiv_fix;
      e_idiv_fix:  state_d = e_idiv_idle;
      default:     state_d = e_idiv_idle;
    endcase
    if (flush_i) state_d = e_idiv_idle;
  end

  // FSM outputs: ready, accept, iteration start and queue push.
  always_comb begin
    ready_and_o = (state_q == e_idiv_idle) && (q_count < cnt_w_lp'(els_p)) && !flush_i;
    accept      = v_i && ready_and_o;
    start       = accept && !fast;
    push        = (state_q == e_idiv_fix) && !flush_i;
  end

  bp_be_idiv_iter_core #(.width_p(width_p), .n_width_p(n_w_lp)) core (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .start_i     (start),
    .kill_i      (flush_i),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .n_i         (opw_i ? n_w_lp'(word_width_p) : n_w_lp'(width_p)),
    .quotient_o  (quo),
    .remainder_o (rem),
    .done_o      (core_done)
  );

  // Sign correction and W-form narrowing of the final result.
  always_comb begin
    if (special_q)     res_raw = spec_res_q;
    else if (is_rem_q) res_raw = r_neg_q ? -rem : rem;
    else               res_raw = q_neg_q ? -quo : quo;
    res = opw_q ? {{ext_lp{res_raw[word_width_p-1]}}, res_raw[word_width_p-1:0]} : res_raw;
  end

  bsg_fifo_1r1w_small #(.width_p(width_p + rd_addr_width_p), .els_p(els_p), .cnt_width_p(cnt_w_lp)) queue (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (flush_i),
    .v_i       (push),
    .data_i    ({res, rd_q}),
    .v_o       (v_o),
    .data_o    ({data_o, rd_addr_o}),
    .yumi_i    (yumi_i),
    .count_o   (q_count)
  );

  // Consumer may only take a valid head.
  always_ff @(posedge clk_i) begin
    if (reset_n_i) assert (!(yumi_i && !v_o));
  end

endmodule
